// File: rtl/divider_pkg.sv
// Shared types and constants for the restoring-division controller.
//   state_t  : FSM encoding (IDLE, LOAD_DIVISOR, ITER, WRITE, DONE)
//   DIV_WIDTH: default operand width
//   cnt_w()  : width of the iteration counter for a given operand width
package divider_pkg;
  localparam int DIV_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_DIVISOR,
    ITER,
    WRITE,
    DONE
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/divider_ctrl_if.sv
// Handshake/strobe bundle between the requester, the controller and the
// datapath.
//   master: drives start, abort, DataIn; observes status and strobes
//   slave : the controller; drives ready, busy, ld_D, ld_d, load_res,
//           result_valid, done, div_by_zero, iter_count
interface divider_ctrl_if
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  localparam int CW = cnt_w(WIDTH);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] DataIn;
  logic             ready;
  logic             busy;
  logic             ld_D;
  logic             ld_d;
  logic             load_res;
  logic             result_valid;
  logic             done;
  logic             div_by_zero;
  logic [CW-1:0]    iter_count;

  modport master (
    output start, abort, DataIn,
    input  ready, busy, ld_D, ld_d, load_res, result_valid, done,
           div_by_zero, iter_count
  );

  modport slave (
    input  start, abort, DataIn,
    output ready, busy, ld_D, ld_d, load_res, result_valid, done,
           div_by_zero, iter_count
  );
endinterface

// File: rtl/divider_datapath.sv
// Restoring-division datapath driven by divider_ctrl strobes.
//   i_data         : shared DataIn bus
//   i_ld_D         : dividend/quotient register enable
//   i_load_res     : with i_ld_D, selects one shift/subtract step
//   i_ld_d         : divisor register enable
//   i_result_valid : commit strobe for o_quotient/o_remainder
module divider_datapath #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ld_D,
  input  logic             i_ld_d,
  input  logic             i_load_res,
  input  logic             i_result_valid,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);
  logic [WIDTH-1:0] r_D;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH:0]   r_A;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_sub;
  logic             w_ge;

  // Partial remainder stays below the divisor, so its low WIDTH bits suffice.
  assign w_shift = {r_A[WIDTH-1:0], r_D[WIDTH-1]};
  assign w_ge    = w_shift >= {1'b0, r_d};
  assign w_sub   = w_shift - {1'b0, r_d};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_D         <= '0;
      r_d         <= '0;
      r_A         <= '0;
      o_quotient  <= '0;
      o_remainder <= '0;
    end else begin
      if (i_ld_D) begin
        if (i_load_res) begin
          r_A <= w_ge ? w_sub : w_shift;
          r_D <= {r_D[WIDTH-2:0], w_ge};
        end else begin
          r_D <= i_data;
          r_A <= '0;
        end
      end
      if (i_ld_d) r_d <= i_data;
      if (i_result_valid) begin
        o_quotient  <= r_D;
        o_remainder <= r_A[WIDTH-1:0];
      end
    end
  end
endmodule

// File: rtl/divider_ctrl.sv
// Sequencing FSM for a WIDTH-bit restoring divider.
//   clk, reset : clock (rising edge), async active-high reset
//   ctl        : slave side of divider_ctrl_if
// Flow: IDLE (capture dividend on start) -> LOAD_DIVISOR (capture divisor,
// zero check) -> ITER x WIDTH -> WRITE (commit) -> DONE (pulse) -> IDLE.
// Strobes are a combinational decode of state; state, counter and the
// sticky zero-divisor flag are registered.
module divider_ctrl
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  divider_ctrl_if.slave ctl
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        r_state;
  logic [CW-1:0] r_iter;
  logic          r_dbz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_iter  <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // start beats a simultaneous abort; abort alone is a no-op here
          if (ctl.start) begin
            r_dbz   <= 1'b0;
            r_state <= LOAD_DIVISOR;
          end
        end
        LOAD_DIVISOR: begin
          r_iter <= '0;
          if (ctl.abort) begin
            r_state <= IDLE;
          end else if (ctl.DataIn == '0) begin
            r_dbz   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_state <= ITER;
          end
        end
        ITER: begin
          if (ctl.abort) begin
            r_iter  <= '0;
            r_state <= IDLE;
          end else if (r_iter == LAST) begin
            r_iter  <= '0;
            r_state <= WRITE;
          end else begin
            r_iter <= r_iter + 1'b1;
          end
        end
        WRITE: begin
          r_iter  <= '0;
          r_state <= ctl.abort ? IDLE : DONE;
        end
        DONE: begin
          r_iter  <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_iter  <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // An abort cycle drops every strobe so the datapath never sees a partial step.
  always_comb begin
    ctl.ready        = 1'b0;
    ctl.busy         = 1'b1;
    ctl.ld_D         = 1'b0;
    ctl.ld_d         = 1'b0;
    ctl.load_res     = 1'b0;
    ctl.result_valid = 1'b0;
    ctl.done         = 1'b0;
    case (r_state)
      IDLE: begin
        ctl.ready = 1'b1;
        ctl.busy  = 1'b0;
        ctl.ld_D  = ctl.start;
      end
      LOAD_DIVISOR: ctl.ld_d = ~ctl.abort;
      ITER: begin
        ctl.ld_D     = ~ctl.abort;
        ctl.load_res = ~ctl.abort;
      end
      WRITE:   ctl.result_valid = ~ctl.abort;
      DONE:    ctl.done = 1'b1;
      default: ;
    endcase
  end

  assign ctl.iter_count  = r_iter;
  assign ctl.div_by_zero = r_dbz;
endmodule

// File: tb/tb_divider_ctrl.sv
module tb_divider_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  divider_ctrl_if #(.WIDTH(4)) bus ();

  divider_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (bus.slave)
  );

  logic [3:0] quo, rem;
  divider_datapath #(.WIDTH(4)) dp (
    .clk            (clk),
    .reset          (reset),
    .i_data         (bus.DataIn),
    .i_ld_D         (bus.ld_D),
    .i_ld_d         (bus.ld_d),
    .i_load_res     (bus.load_res),
    .i_result_valid (bus.result_valid),
    .o_quotient     (quo),
    .o_remainder    (rem)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // {ready, busy, ld_D, ld_d, load_res, result_valid, done}
  wire [6:0] obs = {bus.ready, bus.busy, bus.ld_D, bus.ld_d,
                    bus.load_res, bus.result_valid, bus.done};

  // Drive one cycle's inputs just after the rising edge, return at the falling edge.
  task automatic apply(input logic s, input logic a, input logic [3:0] d);
    @(posedge clk);
    #1;
    bus.start  = s;
    bus.abort  = a;
    bus.DataIn = d;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.DataIn = 4'h0;
    #12;
    n_tests++;
    if (obs !== 7'b1000000) begin
      n_fail++; $display("FAIL reset_strobes got=%b exp=%b", obs, 7'b1000000);
    end
    n_tests++;
    if (bus.iter_count !== 3'd0 || bus.div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL reset_regs got iter=%0d dbz=%b exp iter=0 dbz=0",
                         bus.iter_count, bus.div_by_zero);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Full nonzero-divisor operation, cycles 0..7; optional stray starts in 1..6.
  task automatic test_op(input string nm, input logic [3:0] dvd, input logic [3:0] dvs,
                         input logic [3:0] q, input logic [3:0] r, input logic junk);
    logic [6:0] ev;
    logic [2:0] ei;
    for (int c = 0; c < 8; c++) begin
      apply((c == 0) || (junk && c >= 1 && c <= 6), 1'b0,
            (c == 0) ? dvd : ((c == 1) ? dvs : 4'h0));
      case (c)
        0:       ev = 7'b1010000;
        1:       ev = 7'b0101000;
        6:       ev = 7'b0100010;
        7:       ev = 7'b0100001;
        default: ev = 7'b0110100;
      endcase
      ei = (c >= 2 && c <= 5) ? 3'(c - 2) : 3'd0;
      n_tests++;
      if (obs !== ev) begin
        n_fail++; $display("FAIL %s_c%0d_strobes got=%b exp=%b", nm, c, obs, ev);
      end
      n_tests++;
      if (bus.iter_count !== ei) begin
        n_fail++; $display("FAIL %s_c%0d_iter got=%0d exp=%0d", nm, c, bus.iter_count, ei);
      end
      if (c >= 1) begin
        n_tests++;
        if (bus.div_by_zero !== 1'b0) begin
          n_fail++; $display("FAIL %s_c%0d_dbz got=%b exp=0", nm, c, bus.div_by_zero);
        end
      end
      if (c == 7) begin
        n_tests++;
        if (quo !== q || rem !== r) begin
          n_fail++; $display("FAIL %s_result got Q=%0d R=%0d exp Q=%0d R=%0d", nm, quo, rem, q, r);
        end
      end
    end
  endtask

  task automatic check_idle(input string nm, input int n);
    for (int c = 0; c < n; c++) begin
      apply(1'b0, 1'b0, 4'h0);
      n_tests++;
      if (obs !== 7'b1000000 || bus.iter_count !== 3'd0) begin
        n_fail++; $display("FAIL %s_idle%0d got=%b iter=%0d exp=1000000 iter=0",
                           nm, c, obs, bus.iter_count);
      end
    end
  endtask

  task automatic test_nominal();
    test_op("nominal", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
    check_idle("nominal", 1);
  endtask

  task automatic test_div_zero();
    apply(1'b1, 1'b0, 4'd9);
    n_tests++;
    if (obs !== 7'b1010000) begin
      n_fail++; $display("FAIL dz_c0 got=%b exp=1010000", obs);
    end
    apply(1'b0, 1'b0, 4'd0);
    n_tests++;
    if (obs !== 7'b0101000) begin
      n_fail++; $display("FAIL dz_c1 got=%b exp=0101000", obs);
    end
    apply(1'b0, 1'b0, 4'd0);
    n_tests++;
    if (obs !== 7'b0100001 || bus.div_by_zero !== 1'b1) begin
      n_fail++; $display("FAIL dz_c2 got=%b dbz=%b exp=0100001 dbz=1", obs, bus.div_by_zero);
    end
    for (int c = 0; c < 2; c++) begin
      apply(1'b0, 1'b0, 4'd0);
      n_tests++;
      if (obs !== 7'b1000000 || bus.div_by_zero !== 1'b1) begin
        n_fail++; $display("FAIL dz_hold%0d got=%b dbz=%b exp=1000000 dbz=1",
                           c, obs, bus.div_by_zero);
      end
    end
    test_op("after_dz", 4'd12, 4'd5, 4'd2, 4'd2, 1'b0);
    check_idle("after_dz", 1);
  endtask

  task automatic test_start_busy();
    test_op("busy_start", 4'd15, 4'd15, 4'd1, 4'd0, 1'b1);
    check_idle("busy_start", 2);
  endtask

  task automatic test_abort();
    // start + abort together in IDLE: start wins
    apply(1'b1, 1'b1, 4'd8);
    n_tests++;
    if (obs !== 7'b1010000) begin
      n_fail++; $display("FAIL abort_startwins got=%b exp=1010000", obs);
    end
    // abort in LOAD_DIVISOR
    apply(1'b0, 1'b1, 4'd0);
    n_tests++;
    if (obs !== 7'b0100000) begin
      n_fail++; $display("FAIL abort_ld got=%b exp=0100000", obs);
    end
    check_idle("abort_ld", 1);
    // abort at iter_count==2
    apply(1'b1, 1'b0, 4'd11);
    apply(1'b0, 1'b0, 4'd5);
    apply(1'b0, 1'b0, 4'd0);
    apply(1'b0, 1'b0, 4'd0);
    apply(1'b0, 1'b1, 4'd0);
    n_tests++;
    if (obs !== 7'b0100000 || bus.iter_count !== 3'd2) begin
      n_fail++; $display("FAIL abort_iter got=%b iter=%0d exp=0100000 iter=2", obs, bus.iter_count);
    end
    check_idle("abort_iter", 4);
    test_op("zero_dvd", 4'd0, 4'd5, 4'd0, 4'd0, 1'b0);
    check_idle("zero_dvd", 1);
  endtask

  task automatic test_async_reset();
    apply(1'b1, 1'b0, 4'd6);
    apply(1'b0, 1'b0, 4'd2);
    apply(1'b0, 1'b0, 4'd0);
    apply(1'b0, 1'b0, 4'd0);
    n_tests++;
    if (obs !== 7'b0110100 || bus.iter_count !== 3'd1) begin
      n_fail++; $display("FAIL arst_pre got=%b iter=%0d exp=0110100 iter=1", obs, bus.iter_count);
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (obs !== 7'b1000000 || bus.iter_count !== 3'd0) begin
      n_fail++; $display("FAIL arst_now got=%b iter=%0d exp=1000000 iter=0", obs, bus.iter_count);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    check_idle("arst_after", 8);
  endtask

  task automatic test_back_to_back();
    test_op("b2b_a", 4'd14, 4'd4, 4'd3, 4'd2, 1'b0);
    test_op("b2b_b", 4'd7, 4'd2, 4'd3, 4'd1, 1'b0);
    check_idle("b2b", 1);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_div_zero();
    test_start_busy();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
